// File: rtl/bp_mem_cmd_arbiter.sv
// Shares one memory command/response port between two requesters, routing responses by tag FIFO.
// Define BP_MEM_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins) instead of round-robin.
module bp_mem_cmd_arbiter #(
    parameter int unsigned msg_width_p       = 128,
    parameter int unsigned max_outstanding_p = 8
) (
    input  logic                                     clk_i,
    input  logic                                     reset_n_i,

    input  logic [msg_width_p-1:0]                   req0_cmd_i,
    input  logic                                     req0_cmd_v_i,
    output logic                                     req0_cmd_ready_o,

    input  logic [msg_width_p-1:0]                   req1_cmd_i,
    input  logic                                     req1_cmd_v_i,
    output logic                                     req1_cmd_ready_o,

    output logic [msg_width_p-1:0]                   req0_resp_o,
    output logic                                     req0_resp_v_o,
    input  logic                                     req0_resp_ready_i,

    output logic [msg_width_p-1:0]                   req1_resp_o,
    output logic                                     req1_resp_v_o,
    input  logic                                     req1_resp_ready_i,

    output logic [msg_width_p-1:0]                   mem_cmd_o,
    output logic                                     mem_cmd_v_o,
    input  logic                                     mem_cmd_ready_i,

    input  logic [msg_width_p-1:0]                   mem_resp_i,
    input  logic                                     mem_resp_v_i,
    output logic                                     mem_resp_ready_o,

    output logic [$clog2(max_outstanding_p+1)-1:0]   outstanding_o,
    output logic                                     error_o
);

    localparam int unsigned CntW = $clog2(max_outstanding_p + 1);
    localparam int unsigned PtrW = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
    localparam logic [CntW-1:0] CntMax  = CntW'(max_outstanding_p);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(max_outstanding_p - 1);

    logic [max_outstanding_p-1:0] tag_q;
    logic [PtrW-1:0]              wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]              count_q, count_d;
    logic                         lock_q, lock_id_q, error_q;
`ifndef BP_MEM_ARB_FIXED_PRIO_EN
    logic                         last_q;
`endif

    logic       full, empty, head, pop, push, can_push, sel;
    logic [1:0] elig;

    assign full  = (count_q == CntMax);
    assign empty = (count_q == '0);
    assign head  = tag_q[rd_ptr_q];

    // Response steering: the oldest tag names the requester that owns the returning response.
    always_comb begin
        req0_resp_v_o    = 1'b0;
        req1_resp_v_o    = 1'b0;
        mem_resp_ready_o = 1'b0;
        if (reset_n_i && !empty) begin
            req0_resp_v_o    = mem_resp_v_i && !head;
            req1_resp_v_o    = mem_resp_v_i && head;
            mem_resp_ready_o = head ? req1_resp_ready_i : req0_resp_ready_i;
        end
    end

    assign req0_resp_o = mem_resp_i;
    assign req1_resp_o = mem_resp_i;

    assign pop      = mem_resp_v_i && mem_resp_ready_o;
    // A same-cycle pop frees the slot a push on a full FIFO needs.
    assign can_push = !full || pop;
    assign elig     = {req1_cmd_v_i, req0_cmd_v_i} & {2{can_push}};

    always_comb begin
        if (lock_q) begin
            sel = lock_id_q;
        end else if (&elig) begin
`ifdef BP_MEM_ARB_FIXED_PRIO_EN
            sel = 1'b0;
`else
            sel = ~last_q;
`endif
        end else begin
            sel = elig[1];
        end
    end

    assign mem_cmd_o        = sel ? req1_cmd_i : req0_cmd_i;
    assign mem_cmd_v_o      = reset_n_i && elig[sel];
    assign req0_cmd_ready_o = reset_n_i && !sel && mem_cmd_ready_i && can_push;
    assign req1_cmd_ready_o = reset_n_i && sel && mem_cmd_ready_i && can_push;

    assign push = mem_cmd_v_o && mem_cmd_ready_i;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_n_i && push) begin
            tag_q[wr_ptr_q] <= sel;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            lock_q    <= 1'b0;
            lock_id_q <= 1'b0;
            error_q   <= 1'b0;
`ifndef BP_MEM_ARB_FIXED_PRIO_EN
            last_q    <= 1'b1;
`endif
        end else begin
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrW'(1);
                lock_q   <= 1'b0;
`ifndef BP_MEM_ARB_FIXED_PRIO_EN
                last_q   <= sel;
`endif
            end else if (mem_cmd_v_o) begin
                lock_q    <= 1'b1;
                lock_id_q <= sel;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrW'(1);
            end
            if (mem_resp_v_i && empty) begin
                error_q <= 1'b1;
            end
        end
    end

    assign outstanding_o = count_q;
    assign error_o       = error_q;

endmodule

// File: tb/tb_bp_mem_cmd_arbiter.sv
// Self-checking bench for bp_mem_cmd_arbiter: directed plan steps plus a randomized phase,
// every cycle compared against a queue-based model of the arbitration and steering rules.
module tb_bp_mem_cmd_arbiter;

    localparam int W = 16;
    localparam int D = 8;
    localparam int CW = $clog2(D + 1);

    logic          clk_i = 1'b0;
    logic          reset_n_i;
    logic [W-1:0]  req0_cmd_i, req1_cmd_i, mem_resp_i;
    logic          req0_cmd_v_i, req1_cmd_v_i;
    logic          req0_cmd_ready_o, req1_cmd_ready_o;
    logic [W-1:0]  req0_resp_o, req1_resp_o, mem_cmd_o;
    logic          req0_resp_v_o, req1_resp_v_o, req0_resp_ready_i, req1_resp_ready_i;
    logic          mem_cmd_v_o, mem_cmd_ready_i, mem_resp_v_i, mem_resp_ready_o;
    logic [CW-1:0] outstanding_o;
    logic          error_o;

    always #5 clk_i = ~clk_i;

    bp_mem_cmd_arbiter #(
        .msg_width_p       (W),
        .max_outstanding_p (D)
    ) dut (
        .clk_i             (clk_i),
        .reset_n_i         (reset_n_i),
        .req0_cmd_i        (req0_cmd_i),
        .req0_cmd_v_i      (req0_cmd_v_i),
        .req0_cmd_ready_o  (req0_cmd_ready_o),
        .req1_cmd_i        (req1_cmd_i),
        .req1_cmd_v_i      (req1_cmd_v_i),
        .req1_cmd_ready_o  (req1_cmd_ready_o),
        .req0_resp_o       (req0_resp_o),
        .req0_resp_v_o     (req0_resp_v_o),
        .req0_resp_ready_i (req0_resp_ready_i),
        .req1_resp_o       (req1_resp_o),
        .req1_resp_v_o     (req1_resp_v_o),
        .req1_resp_ready_i (req1_resp_ready_i),
        .mem_cmd_o         (mem_cmd_o),
        .mem_cmd_v_o       (mem_cmd_v_o),
        .mem_cmd_ready_i   (mem_cmd_ready_i),
        .mem_resp_i        (mem_resp_i),
        .mem_resp_v_i      (mem_resp_v_i),
        .mem_resp_ready_o  (mem_resp_ready_o),
        .outstanding_o     (outstanding_o),
        .error_o           (error_o)
    );

    int checks = 0;
    int failures = 0;

    // Model: outstanding requester IDs in issue order, a held (stalled) grant, last winner.
    int q[$];
    int held = -1;
    int last = 1;
    bit err = 1'b0;
    int grants[$];
    int hs_id = -1;

    // Values sampled from the DUT just before the edge of the most recent step.
    logic [W-1:0] s_cmd;
    logic s_cmd_hs, s_pop, s_resp_v0, s_resp_v1, s_mem_resp_ready;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        int g;
        int hd;
        bit v0, v1, can_push, pop, push, exp_v;
        #2;
        s_cmd            = mem_cmd_o;
        s_cmd_hs         = mem_cmd_v_o && mem_cmd_ready_i;
        s_pop            = mem_resp_v_i && mem_resp_ready_o;
        s_resp_v0        = req0_resp_v_o;
        s_resp_v1        = req1_resp_v_o;
        s_mem_resp_ready = mem_resp_ready_o;
        hs_id = -1;
        if (!reset_n_i) begin
            chk("rst_mem_cmd_v", mem_cmd_v_o, 0);
            chk("rst_req0_ready", req0_cmd_ready_o, 0);
            chk("rst_req1_ready", req1_cmd_ready_o, 0);
            chk("rst_req0_resp_v", req0_resp_v_o, 0);
            chk("rst_req1_resp_v", req1_resp_v_o, 0);
            chk("rst_mem_resp_ready", mem_resp_ready_o, 0);
            @(posedge clk_i);
            q.delete();
            held = -1;
            last = 1;
            err = 1'b0;
            #1;
            return;
        end
        v0 = req0_cmd_v_i;
        v1 = req1_cmd_v_i;
        hd = (q.size() > 0) ? q[0] : -1;
        pop = mem_resp_v_i && (hd == 0 ? req0_resp_ready_i : (hd == 1 ? req1_resp_ready_i : 1'b0));
        can_push = (q.size() < D) || pop;
        if (held >= 0) g = held;
`ifdef BP_MEM_ARB_FIXED_PRIO_EN
        else if (v0 && v1) g = 0;
`else
        else if (v0 && v1) g = 1 - last;
`endif
        else g = v1 ? 1 : 0;
        exp_v = (g == 1 ? v1 : v0) && can_push;
        chk("mem_cmd_v", mem_cmd_v_o, exp_v);
        if (exp_v) chk("mem_cmd_data", mem_cmd_o, g == 1 ? req1_cmd_i : req0_cmd_i);
        if (v0 || v1) begin
            chk("req0_cmd_ready", req0_cmd_ready_o, g == 0 && mem_cmd_ready_i && can_push);
            chk("req1_cmd_ready", req1_cmd_ready_o, g == 1 && mem_cmd_ready_i && can_push);
        end
        chk("req0_resp_v", req0_resp_v_o, mem_resp_v_i && hd == 0);
        chk("req1_resp_v", req1_resp_v_o, mem_resp_v_i && hd == 1);
        chk("mem_resp_ready", mem_resp_ready_o, pop || (!mem_resp_v_i && hd >= 0 &&
            (hd == 0 ? req0_resp_ready_i : req1_resp_ready_i)));
        if (hd == 0 && mem_resp_v_i) chk("req0_resp_data", req0_resp_o, mem_resp_i);
        if (hd == 1 && mem_resp_v_i) chk("req1_resp_data", req1_resp_o, mem_resp_i);
        chk("outstanding", outstanding_o, q.size());
        chk("error", error_o, err);
        push = exp_v && mem_cmd_ready_i;
        @(posedge clk_i);
        if (mem_resp_v_i && q.size() == 0) err = 1'b1;
        if (pop) void'(q.pop_front());
        if (push) begin
            q.push_back(g);
            last = g;
            held = -1;
            grants.push_back(g);
            hs_id = g;
        end else if (exp_v) begin
            held = g;
        end
        #1;
    endtask

    // New command data only after the current one was accepted (or none was pending).
    task automatic refresh_reqs(input bit keep_valid);
        if (!req0_cmd_v_i || hs_id == 0) begin
            req0_cmd_v_i = keep_valid ? 1'b1 : ($urandom_range(0, 2) != 0);
            req0_cmd_i = W'($urandom);
        end
        if (!req1_cmd_v_i || hs_id == 1) begin
            req1_cmd_v_i = keep_valid ? 1'b1 : ($urandom_range(0, 2) != 0);
            req1_cmd_i = W'($urandom);
        end
    endtask

    task automatic drain();
        req0_resp_ready_i = 1'b1;
        req1_resp_ready_i = 1'b1;
        for (int i = 0; i < 20 && q.size() > 0; i++) begin
            mem_resp_v_i = 1'b1;
            mem_resp_i = W'($urandom);
            step();
        end
        mem_resp_v_i = 1'b0;
        chk("drain_left", outstanding_o, 0);
    endtask

    task automatic issue(input int id, input logic [W-1:0] data);
        mem_cmd_ready_i = 1'b1;
        req0_cmd_v_i = (id == 0);
        req1_cmd_v_i = (id == 1);
        if (id == 0) req0_cmd_i = data;
        else req1_cmd_i = data;
        step();
        chk("issue_hs", s_cmd_hs, 1);
        req0_cmd_v_i = 1'b0;
        req1_cmd_v_i = 1'b0;
    endtask

    initial begin
        // Reset with every input valid asserted.
        reset_n_i = 1'b0;
        req0_cmd_v_i = 1'b1;
        req1_cmd_v_i = 1'b1;
        req0_cmd_i = 16'h0a00;
        req1_cmd_i = 16'h0b00;
        mem_cmd_ready_i = 1'b1;
        mem_resp_v_i = 1'b1;
        mem_resp_i = 16'hdead;
        req0_resp_ready_i = 1'b1;
        req1_resp_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        for (int i = 0; i < 3; i++) step();
        chk("rst_outstanding", outstanding_o, 0);
        chk("rst_error", error_o, 0);

        // Fairness: both valid, downstream always ready, until the tag FIFO fills.
        reset_n_i = 1'b1;
        mem_resp_v_i = 1'b0;
        grants.delete();
        for (int i = 0; i < 10; i++) begin
            step();
            refresh_reqs(1'b1);
        end
        chk("rr_count", grants.size(), D);
        for (int i = 0; i < D && i < grants.size(); i++) begin
`ifdef BP_MEM_ARB_FIXED_PRIO_EN
            chk("prio_grant", grants[i], 0);
`else
            chk("rr_grant", grants[i], i % 2);
`endif
        end
        chk("rr_full_outstanding", outstanding_o, D);
        chk("rr_full_cmd_v", mem_cmd_v_o, 0);

        // Full FIFO: a response pop and a new command in the same cycle.
        mem_resp_v_i = 1'b1;
        mem_resp_i = 16'h5a5a;
        step();
        chk("pp_cmd_hs", s_cmd_hs, 1);
        chk("pp_resp_hs", s_pop, 1);
        chk("pp_outstanding", outstanding_o, D);
        mem_resp_v_i = 1'b0;
        req0_cmd_v_i = 1'b0;
        req1_cmd_v_i = 1'b0;
        drain();

        // Grant lock: req1 stalls, req0 arrives later, req1 must stay on the port.
        mem_cmd_ready_i = 1'b0;
        req1_cmd_v_i = 1'b1;
        req1_cmd_i = 16'h1111;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                req0_cmd_v_i = 1'b1;
                req0_cmd_i = 16'h2222;
            end
            step();
            chk("lock_hold_cmd", s_cmd, 16'h1111);
        end
        mem_cmd_ready_i = 1'b1;
        step();
        chk("lock_first_cmd", s_cmd, 16'h1111);
        chk("lock_first_hs", s_cmd_hs, 1);
        req1_cmd_v_i = 1'b0;
        step();
        chk("lock_second_cmd", s_cmd, 16'h2222);
        chk("lock_second_hs", s_cmd_hs, 1);
        req0_cmd_v_i = 1'b0;
        drain();

        // Response steering: req0, req1, req0 then responses A, B (req1 stalls), C.
        issue(0, 16'h0c01);
        issue(1, 16'h0c02);
        issue(0, 16'h0c03);
        mem_resp_v_i = 1'b1;
        mem_resp_i = 16'haaaa;
        step();
        chk("steer_a_v0", s_resp_v0, 1);
        chk("steer_a_v1", s_resp_v1, 0);
        mem_resp_i = 16'hbbbb;
        req1_resp_ready_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("steer_b_stall_ready", s_mem_resp_ready, 0);
            chk("steer_b_v1", s_resp_v1, 1);
        end
        req1_resp_ready_i = 1'b1;
        step();
        chk("steer_b_ready", s_mem_resp_ready, 1);
        mem_resp_i = 16'hcccc;
        step();
        chk("steer_c_v0", s_resp_v0, 1);
        chk("steer_c_v1", s_resp_v1, 0);
        mem_resp_v_i = 1'b0;

        // Randomized traffic with legal ready/valid behaviour on every requester.
        req0_cmd_v_i = 1'b0;
        req1_cmd_v_i = 1'b0;
        hs_id = -1;
        for (int i = 0; i < 2000; i++) begin
            refresh_reqs(1'b0);
            mem_cmd_ready_i = ($urandom_range(0, 3) != 0);
            req0_resp_ready_i = ($urandom_range(0, 3) != 0);
            req1_resp_ready_i = ($urandom_range(0, 3) != 0);
            mem_resp_v_i = (q.size() > 0) && ($urandom_range(0, 1) == 1);
            mem_resp_i = W'($urandom);
            step();
        end
        mem_cmd_ready_i = 1'b1;
        mem_resp_v_i = 1'b0;
        step();
        req0_cmd_v_i = 1'b0;
        req1_cmd_v_i = 1'b0;
        drain();
        chk("rand_error_clear", error_o, 0);

        // Spurious response with nothing outstanding.
        mem_resp_v_i = 1'b1;
        step();
        chk("spur_resp_ready", s_mem_resp_ready, 0);
        mem_resp_v_i = 1'b0;
        step();
        chk("spur_error_set", error_o, 1);
        step();
        chk("spur_error_sticky", error_o, 1);

        // Reset mid-transaction drops tags; a late response flags an error.
        issue(0, 16'h0d01);
        issue(1, 16'h0d02);
        reset_n_i = 1'b0;
        step();
        reset_n_i = 1'b1;
        step();
        chk("midrst_outstanding", outstanding_o, 0);
        chk("midrst_error_clear", error_o, 0);
        mem_resp_v_i = 1'b1;
        step();
        mem_resp_v_i = 1'b0;
        step();
        chk("midrst_late_error", error_o, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
